// File: rtl/tdm_demux4.sv
// tdm_demux4 - receive-side time-division demultiplexer.
// A stream of W-bit samples arrives one per slot. frame_sync marks slot 0
// of each 4-slot frame. Slots 0..2 are held in staging registers. When slot 3
// arrives, all four slots are published together on p0..p3. The block also
// tracks frame alignment, flags sync errors, and counts frames and errors.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        W-bit sample for the current slot
//   din_vld    din/frame_sync are meaningful this cycle
//   frame_sync marks the current sample as slot 0
//   p0..p3     last complete frame, slots 0..3
//   frame_vld  one-cycle pulse when p0..p3 were just updated
//   slot_vld   one-hot strobe, bit k = slot-k sample accepted
//   locked     aligned to the frame structure
//   sync_err   one-cycle pulse on an alignment error
//   frame_cnt  completed frames, wrapping
//   err_cnt    sync errors, saturating at all-ones
module tdm_demux4 #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             din_vld,
  input  logic             frame_sync,
  output logic [W-1:0]     p0,
  output logic [W-1:0]     p1,
  output logic [W-1:0]     p2,
  output logic [W-1:0]     p3,
  output logic             frame_vld,
  output logic [3:0]       slot_vld,
  output logic             locked,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_slot, w_slot;
  logic [W-1:0]     r_s0, r_s1, r_s2, w_s0, w_s1, w_s2;
  logic [W-1:0]     r_p0, r_p1, r_p2, r_p3, w_p0, w_p1, w_p2, w_p3;
  logic             r_frame_vld, w_frame_vld;
  logic [3:0]       r_slot_vld, w_slot_vld;
  logic             r_sync_err, w_sync_err;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_slot      <= '0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_p3        <= '0;
      r_frame_vld <= 1'b0;
      r_slot_vld  <= '0;
      r_sync_err  <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_slot      <= w_slot;
      r_s0        <= w_s0;
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_p0        <= w_p0;
      r_p1        <= w_p1;
      r_p2        <= w_p2;
      r_p3        <= w_p3;
      r_frame_vld <= w_frame_vld;
      r_slot_vld  <= w_slot_vld;
      r_sync_err  <= w_sync_err;
      r_frame_cnt <= w_frame_cnt;
      r_err_cnt   <= w_err_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_slot      = r_slot;
    w_s0        = r_s0;
    w_s1        = r_s1;
    w_s2        = r_s2;
    w_p0        = r_p0;
    w_p1        = r_p1;
    w_p2        = r_p2;
    w_p3        = r_p3;
    w_frame_vld = 1'b0;
    w_slot_vld  = '0;
    w_sync_err  = 1'b0;
    w_frame_cnt = r_frame_cnt;

    if (din_vld) begin
      if (r_state == HUNT) begin
        // Unsynced samples are silently dropped while hunting.
        if (frame_sync) begin
          w_s0       = din;
          w_slot     = 2'd1;
          w_slot_vld = 4'b0001;
          w_state    = LOCK;
        end
      end else if (frame_sync) begin
        // A sync mid-frame restarts the frame at this sample. Lock is kept.
        w_sync_err = (r_slot != 2'd0);
        w_s0       = din;
        w_slot     = 2'd1;
        w_slot_vld = 4'b0001;
      end else if (r_slot == 2'd0) begin
        w_sync_err = 1'b1;
        w_state    = HUNT;
        w_slot     = 2'd0;
      end else if (r_slot == 2'd3) begin
        w_p0        = r_s0;
        w_p1        = r_s1;
        w_p2        = r_s2;
        w_p3        = din;
        w_frame_vld = 1'b1;
        w_slot_vld  = 4'b1000;
        w_slot      = 2'd0;
        w_frame_cnt = r_frame_cnt + 1'b1;
      end else begin
        if (r_slot == 2'd1) begin
          w_s1 = din;
        end else begin
          w_s2 = din;
        end
        w_slot_vld = 4'b0001 << r_slot;
        w_slot     = r_slot + 2'd1;
      end
    end

    w_err_cnt = r_err_cnt;
    if (w_sync_err && (r_err_cnt != '1)) begin
      w_err_cnt = r_err_cnt + 1'b1;
    end
  end

  assign p0        = r_p0;
  assign p1        = r_p1;
  assign p2        = r_p2;
  assign p3        = r_p3;
  assign frame_vld = r_frame_vld;
  assign slot_vld  = r_slot_vld;
  assign locked    = (r_state == LOCK);
  assign sync_err  = r_sync_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 - directed self-checking bench for tdm_demux4 (W=2).
module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic       din_vld;
  logic       frame_sync;
  logic [1:0] p0, p1, p2, p3;
  logic       frame_vld;
  logic [3:0] slot_vld;
  logic       locked;
  logic       sync_err;
  logic [7:0] frame_cnt;
  logic [3:0] err_cnt;
  logic [7:0] pk;

  int unsigned n_checks;
  int unsigned n_errors;

  tdm_demux4 #(.W(2), .CNT_W(8), .ERR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_vld    (din_vld),
    .frame_sync (frame_sync),
    .p0         (p0),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .frame_vld  (frame_vld),
    .slot_vld   (slot_vld),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  assign pk = {p3, p2, p1, p0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted sample. The outputs are sampled just after the accepting edge.
  task automatic send(input logic sync, input logic [1:0] d);
    @(negedge clk);
    din_vld    = 1'b1;
    frame_sync = sync;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_vld    = 1'b0;
    frame_sync = 1'b1;
    din        = 2'd3;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    din_vld = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    din        = '0;
    din_vld    = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
    check("rst_p",        {24'd0, pk}, 32'h00);
    check("rst_frame_vld", {31'd0, frame_vld}, 32'd0);
    check("rst_slot_vld",  {28'd0, slot_vld}, 32'd0);
    check("rst_locked",    {31'd0, locked}, 32'd0);
    check("rst_sync_err",  {31'd0, sync_err}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("rst_err_cnt",   {28'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back frame 1,2,3,0.
    send(1'b1, 2'd1);
    check("b2b_sv0",    {28'd0, slot_vld}, 32'h1);
    check("b2b_lock",   {31'd0, locked}, 32'd1);
    check("b2b_fv0",    {31'd0, frame_vld}, 32'd0);
    send(1'b0, 2'd2);
    check("b2b_sv1",    {28'd0, slot_vld}, 32'h2);
    send(1'b0, 2'd3);
    check("b2b_sv2",    {28'd0, slot_vld}, 32'h4);
    check("b2b_p_hold", {24'd0, pk}, 32'h00);
    send(1'b0, 2'd0);
    check("b2b_sv3",    {28'd0, slot_vld}, 32'h8);
    check("b2b_fv",     {31'd0, frame_vld}, 32'd1);
    check("b2b_p",      {24'd0, pk}, 32'h39);
    check("b2b_fcnt",   {24'd0, frame_cnt}, 32'd1);
    idle();
    check("b2b_fv_off", {31'd0, frame_vld}, 32'd0);
    check("b2b_sv_off", {28'd0, slot_vld}, 32'h0);

    // Unsynced samples while hunting are dropped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 2'(i + 1));
      check("hunt_lock", {31'd0, locked}, 32'd0);
      check("hunt_sv",   {28'd0, slot_vld}, 32'h0);
      check("hunt_serr", {31'd0, sync_err}, 32'd0);
      check("hunt_p",    {24'd0, pk}, 32'h00);
    end

    // Early sync on slot 2.
    send(1'b1, 2'd2);
    send(1'b0, 2'd3);
    send(1'b1, 2'd1);
    check("early_serr", {31'd0, sync_err}, 32'd1);
    check("early_ecnt", {28'd0, err_cnt}, 32'd1);
    check("early_sv",   {28'd0, slot_vld}, 32'h1);
    check("early_lock", {31'd0, locked}, 32'd1);
    send(1'b0, 2'd1);
    check("early_serr_off", {31'd0, sync_err}, 32'd0);
    send(1'b0, 2'd1);
    send(1'b0, 2'd1);
    check("early_fv", {31'd0, frame_vld}, 32'd1);
    check("early_p",  {24'd0, pk}, 32'h55);
    check("early_fcnt", {24'd0, frame_cnt}, 32'd1);

    // Missing sync after slot 3.
    send(1'b0, 2'd2);
    check("miss_serr", {31'd0, sync_err}, 32'd1);
    check("miss_lock", {31'd0, locked}, 32'd0);
    check("miss_sv",   {28'd0, slot_vld}, 32'h0);
    check("miss_fv",   {31'd0, frame_vld}, 32'd0);
    check("miss_ecnt", {28'd0, err_cnt}, 32'd2);
    check("miss_p",    {24'd0, pk}, 32'h55);
    send(1'b1, 2'd3);
    check("relock",    {31'd0, locked}, 32'd1);
    check("relock_sv", {28'd0, slot_vld}, 32'h1);
    send(1'b0, 2'd0);
    send(1'b0, 2'd1);
    send(1'b0, 2'd2);
    check("relock_p",    {24'd0, pk}, 32'h93);
    check("relock_fcnt", {24'd0, frame_cnt}, 32'd2);

    // Frame with gaps of 0, 1 and 5 idle cycles.
    send(1'b1, 2'd1);
    send(1'b0, 2'd2);
    idle();
    check("gap1_sv", {28'd0, slot_vld}, 32'h0);
    send(1'b0, 2'd3);
    check("gap_sv2", {28'd0, slot_vld}, 32'h4);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("gap5_fv",   {31'd0, frame_vld}, 32'd0);
      check("gap5_lock", {31'd0, locked}, 32'd1);
      check("gap5_p",    {24'd0, pk}, 32'h93);
    end
    send(1'b0, 2'd0);
    check("gap_fv",   {31'd0, frame_vld}, 32'd1);
    check("gap_sv3",  {28'd0, slot_vld}, 32'h8);
    check("gap_p",    {24'd0, pk}, 32'h39);
    check("gap_fcnt", {24'd0, frame_cnt}, 32'd3);

    // 17 consecutive early-sync errors; err_cnt saturates at 15.
    do_reset();
    send(1'b1, 2'd0);
    for (int i = 1; i <= 17; i++) begin
      send(1'b1, 2'd0);
      check("sat_serr", {31'd0, sync_err}, 32'd1);
      check("sat_fv",   {31'd0, frame_vld}, 32'd0);
      check("sat_ecnt", {28'd0, err_cnt}, (i < 15) ? 32'(i) : 32'd15);
    end

    // 256 good frames: frame_cnt wraps to 0.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      send(1'b1, 2'd1);
      send(1'b0, 2'd2);
      send(1'b0, 2'd3);
      send(1'b0, 2'(f));
      if (f == 254) check("wrap_255", {24'd0, frame_cnt}, 32'd255);
    end
    check("wrap_0",  {24'd0, frame_cnt}, 32'd0);
    check("wrap_p",  {24'd0, pk}, 32'hF9);
    check("wrap_ec", {28'd0, err_cnt}, 32'd0);

    // Reset mid-frame, with a valid sample on the same edge.
    send(1'b1, 2'd2);
    send(1'b0, 2'd1);
    @(negedge clk);
    rst        = 1'b1;
    din_vld    = 1'b1;
    frame_sync = 1'b0;
    din        = 2'd3;
    @(posedge clk);
    #1;
    check("mrst_p",    {24'd0, pk}, 32'h00);
    check("mrst_sv",   {28'd0, slot_vld}, 32'h0);
    check("mrst_lock", {31'd0, locked}, 32'd0);
    check("mrst_fv",   {31'd0, frame_vld}, 32'd0);
    check("mrst_fcnt", {24'd0, frame_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 2'd3);
    check("mrst_hunt_lock", {31'd0, locked}, 32'd0);
    check("mrst_hunt_sv",   {28'd0, slot_vld}, 32'h0);
    check("mrst_hunt_serr", {31'd0, sync_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
